// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO with first-word-fall-through read: BRAM, fetch stage, output register.
// Define FIFO_ERR_FLAGS_EN to enable the sticky overflow/underflow flags.
module fifo_sync_fwft #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned AFULL_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_afull,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow,
  input  logic                  i_clr_err
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] bram_data_q;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  bram_vld_q, bram_vld_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic          wr_acc_c;
  logic          rd_acc_c;
  logic          out_load_c;
  logic          issue_c;
  logic [CW-1:0] mem_words_c;

  // Words still in memory = total minus those already in the fetch stage and output register.
  always_comb begin
    wr_acc_c    = i_wr_en && !full_q && !i_flush;
    rd_acc_c    = i_rd_en && rd_valid_q && !i_flush;
    mem_words_c = count_q - CW'(rd_valid_q) - CW'(bram_vld_q);
    out_load_c  = !i_flush && bram_vld_q && (!rd_valid_q || rd_acc_c);
    issue_c     = !i_flush && (mem_words_c != '0) && (!bram_vld_q || out_load_c);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    bram_vld_d = bram_vld_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      bram_vld_d = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      if (issue_c)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      count_d = count_q + CW'(wr_acc_c) - CW'(rd_acc_c);

      if (issue_c)         bram_vld_d = 1'b1;
      else if (out_load_c) bram_vld_d = 1'b0;

      if (out_load_c) begin
        rd_valid_d = 1'b1;
        rd_data_d  = bram_data_q;
      end else if (rd_acc_c) begin
        rd_valid_d = 1'b0;
      end
    end

    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      bram_vld_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      bram_vld_q <= bram_vld_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage array and its registered read port carry no reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc_c) mem_q[wr_ptr_q] <= i_wr_data;
    if (issue_c)  bram_data_q     <= mem_q[rd_ptr_q];
  end

  assign o_full     = full_q;
  assign o_afull    = afull_q;
  assign o_aempty   = aempty_q;
  assign o_count    = count_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; a new event in the clear cycle keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q && !i_clr_err) || (i_wr_en && full_q);
    unf_d = (unf_q && !i_clr_err) || (i_rd_en && !rd_valid_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = i_clr_err;
  assign o_overflow     = 1'b0;
  assign o_underflow    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Bench for fifo_sync_fwft: queue-based reference model checked every cycle plus directed literal checks.
module tb_fifo_sync_fwft;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_wr_en;
  logic [DW-1:0] i_wr_data;
  logic          o_full;
  logic          o_afull;
  logic          i_rd_en;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid;
  logic          o_aempty;
  logic [AW:0]   o_count;
  logic          o_overflow;
  logic          o_underflow;
  logic          i_clr_err;

  int errors = 0;
  int checks = 0;

  fifo_sync_fwft #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush),
    .i_wr_en(i_wr_en), .i_wr_data(i_wr_data), .o_full(o_full), .o_afull(o_afull),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
    .o_aempty(o_aempty), .o_count(o_count), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .i_clr_err(i_clr_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words tagged with the edge index that wrote them.
  // A head word is visible two edges after its write, and no earlier than the pop that exposed it.
  typedef struct {
    logic [DW-1:0] d;
    int            w;
  } ent_t;

  ent_t q[$];
  int   cyc        = 0;
  int   head_since = 0;
  bit   m_ovf      = 1'b0;
  bit   m_unf      = 1'b0;

  function automatic bit m_valid();
    if (q.size() == 0) return 1'b0;
    return (cyc >= q[0].w + 2) && (cyc >= head_since);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q.delete();
      cyc        = 0;
      head_since = 0;
      m_ovf      = 1'b0;
      m_unf      = 1'b0;
    end else begin
      bit vpre;
      bit fullpre;
      vpre    = m_valid();
      fullpre = (q.size() == 16);
      cyc++;
      m_ovf = (m_ovf && !i_clr_err) || (i_wr_en && fullpre);
      m_unf = (m_unf && !i_clr_err) || (i_rd_en && !vpre);
      if (i_flush) begin
        q.delete();
      end else begin
        if (i_rd_en && vpre) begin
          void'(q.pop_front());
          head_since = cyc;
        end
        if (i_wr_en && !fullpre) q.push_back('{d: i_wr_data, w: cyc});
      end
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge i_clk) begin
    if (i_rst_n === 1'b1) begin
      chk("count", 32'(o_count), 32'(q.size()));
      chk("full", 32'(o_full), 32'(q.size() == 16));
      chk("afull", 32'(o_afull), 32'(q.size() >= 12));
      chk("aempty", 32'(o_aempty), 32'(q.size() <= 4));
      chk("rd_valid", 32'(o_rd_valid), 32'(m_valid()));
      if (m_valid()) chk("rd_data", 32'(o_rd_data), 32'(q[0].d));
      chk("overflow", 32'(o_overflow), 32'(ERR_EN & m_ovf));
      chk("underflow", 32'(o_underflow), 32'(ERR_EN & m_unf));
    end
  end

  // Called at a negedge: apply inputs, return at the next negedge after they took effect.
  task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                      input bit fl, input bit clr);
    i_wr_en   = wr;
    i_wr_data = d;
    i_rd_en   = rd;
    i_flush   = fl;
    i_clr_err = clr;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_count"}, 32'(o_count), 32'd0);
    chk({tag, "_valid"}, 32'(o_rd_valid), 32'd0);
    chk({tag, "_data"}, 32'(o_rd_data), 32'd0);
    chk({tag, "_full"}, 32'(o_full), 32'd0);
    chk({tag, "_afull"}, 32'(o_afull), 32'd0);
    chk({tag, "_aempty"}, 32'(o_aempty), 32'd1);
    chk({tag, "_ovf"}, 32'(o_overflow), 32'd0);
    chk({tag, "_unf"}, 32'(o_underflow), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_rd_en = 1'b0; i_clr_err = 1'b0;
    repeat (2) @(negedge i_clk);
    chk_reset_values("rst");
    i_rst_n = 1'b1;
    idle(1);

    // Single write: count after T, visible after T+2.
    step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("single_count_T", 32'(o_count), 32'd1);
    chk("single_valid_T", 32'(o_rd_valid), 32'd0);
    idle(1);
    chk("single_valid_T1", 32'(o_rd_valid), 32'd0);
    idle(1);
    chk("single_valid_T2", 32'(o_rd_valid), 32'd1);
    chk("single_data_T2", 32'(o_rd_data), 32'hA5);
    chk("single_aempty", 32'(o_aempty), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("single_pop_count", 32'(o_count), 32'd0);

    // Fill to full, then one dropped write.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      chk("fill_afull", 32'(o_afull), 32'(i + 1 >= 12));
    end
    chk("fill_full", 32'(o_full), 32'd1);
    step(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("drop_count", 32'(o_count), 32'd16);
    chk("drop_ovf", 32'(o_overflow), 32'(ERR_EN));

    // Drain at full rate: every cycle shows the next word.
    for (int i = 0; i < 16; i++) begin
      chk("drain_valid", 32'(o_rd_valid), 32'd1);
      chk("drain_data", 32'(o_rd_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    chk("drain_valid_end", 32'(o_rd_valid), 32'd0);
    chk("drain_count_end", 32'(o_count), 32'd0);
    chk("drain_aempty_end", 32'(o_aempty), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("underflow_set", 32'(o_underflow), 32'(ERR_EN));

    // Steady state at count 8 with simultaneous write and pop across wrap.
    for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0, 1'b0);
    idle(2);
    for (int k = 0; k < 40; k++) begin
      chk("stream_data", 32'(o_rd_data), 32'(8'h40 + k));
      step(1'b1, 8'(8'h48 + k), 1'b1, 1'b0, 1'b0);
      chk("stream_count", 32'(o_count), 32'd8);
    end

    // Flush at count 10 overrides a concurrent write and pop.
    step(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    chk("preflush_count", 32'(o_count), 32'd10);
    step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_valid", 32'(o_rd_valid), 32'd0);
    chk("flush_full", 32'(o_full), 32'd0);
    idle(3);
    chk("flush_nostore_count", 32'(o_count), 32'd0);
    chk("flush_nostore_valid", 32'(o_rd_valid), 32'd0);
    chk("flush_keeps_ovf", 32'(o_overflow), 32'(ERR_EN));

    // Clear sticky flags, then set-wins-over-clear while full.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(o_overflow), 32'd0);
    chk("clr_unf", 32'(o_underflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("setwins_ovf", 32'(o_overflow), 32'(ERR_EN));

    // Asynchronous reset mid-stream.
    step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    @(posedge i_clk);
    #3;
    i_rst_n = 1'b0;
    #1;
    chk_reset_values("async");
    i_wr_en = 1'b0; i_rd_en = 1'b0; i_clr_err = 1'b0; i_flush = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle(1);
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(o_count), 32'd1);
    chk("post_rst_valid_T", 32'(o_rd_valid), 32'd0);
    idle(1);
    chk("post_rst_valid_T1", 32'(o_rd_valid), 32'd0);
    idle(1);
    chk("post_rst_valid_T2", 32'(o_rd_valid), 32'd1);
    chk("post_rst_data_T2", 32'(o_rd_data), 32'h3C);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
- Single-clock, parametrised FIFO with first-word-fall-through (FWFT) read side. It is the general-purpose successor to the plain dual-port FIFO RAM.
- Owns its BRAM storage, pointers, fill count, almost-full/almost-empty flags and a synchronous flush.
- Sits between the MAC RX/TX byte paths and the packet-processing logic where both sides share one clock.

Parameters:
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 8: pointer width; DEPTH = 2**ADDR_WIDTH.
- AFULL_THRESH, 2**ADDR_WIDTH-4: o_afull asserts when count >= this value.
- AEMPTY_THRESH, 4: o_aempty asserts when count <= this value.

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous clear of contents.
- i_wr_en  in  1  write request.
- i_wr_data  in  DATA_WIDTH  write data.
- o_full  out  1  count == DEPTH.
- o_afull  out  1  almost full.
- i_rd_en  in  1  pop; acts only when o_rd_valid=1.
- o_rd_data  out  DATA_WIDTH  head word; valid when o_rd_valid=1.
- o_rd_valid  out  1  head word present.
- o_aempty  out  1  almost empty.
- o_count  out  ADDR_WIDTH+1  words accepted and not yet popped.
- o_overflow  out  1  sticky: write attempted while full.
- o_underflow  out  1  sticky: pop attempted while !o_rd_valid.
- i_clr_err  in  1  clears sticky flags.

Behaviour:
- Reset (i_rst_n low, async): pointers=0, count=0, o_rd_valid=0, o_rd_data=0, o_full=0, o_afull=0, o_aempty=1, o_overflow=0, o_underflow=0. Memory contents are not cleared.
- Write accepted iff i_wr_en && !o_full. A write while full is dropped, and contents are unchanged.
- Pop accepted iff i_rd_en && o_rd_valid. i_rd_en while !o_rd_valid is ignored.
- Full is evaluated pre-edge: a write is rejected when o_full=1, even if a pop is accepted in the same cycle.
- Storage is a registered-read BRAM (one-cycle read latency) followed by an output register. Prefetch logic keeps the output register filled whenever the memory holds data.
- FWFT latency: a write accepted at edge T into an empty FIFO gives o_rd_valid=1 and o_rd_data=that word after edge T+2.
- Back-to-back pops at full rate: each accepted pop presents the next word in the following cycle, with no bubbles while data is available.
- o_rd_data holds its value while o_rd_valid=1 and no pop is accepted.
- Count: o_count(next) = o_count + wr_acc - rd_acc, registered. Simultaneous accepted write and pop leave the count unchanged. o_count may be >0 while o_rd_valid=0 during the fill latency.
- Flags are registered from the next count: o_full = (count==DEPTH), o_afull = (count>=AFULL_THRESH), o_aempty = (count<=AEMPTY_THRESH).
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH with no special case at wrap-around.
- Flush (i_flush=1 at an edge): same effect as reset on pointers, count, o_rd_valid and flags; o_rd_data keeps its value. Flush overrides any write or pop in the same cycle.
- Async reset mid-operation discards all in-flight prefetch state. The first write after release follows the T+2 latency.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined:
  - o_overflow sets on i_wr_en && o_full.
  - o_underflow sets on i_rd_en && !o_rd_valid.
  - Both flags stay set until i_clr_err=1 or reset. Flush does not clear them.
  - If set and clear occur in the same cycle, set wins.
- Undefined: o_overflow and o_underflow are tied to 0, and i_clr_err is ignored.

Test Plan (ADDR_WIDTH=4, DEPTH=16, AFULL_THRESH=12, AEMPTY_THRESH=4, DATA_WIDTH=8):
- Reset, then a single write of 0xA5 at edge T:
  - o_count=1 after T.
  - o_rd_valid=1 and o_rd_data=0xA5 after T+2.
  - o_aempty stays 1.
- Write 0x00..0x0F on consecutive cycles with no pops:
  - o_afull rises when count reaches 12; o_full=1 after the 16th write.
  - A 17th write (0xFF) is dropped, o_count stays 16, and o_overflow=1 with the macro defined.
- From full, pop continuously:
  - o_rd_data sequence is 0x00..0x0F with no gaps.
  - o_rd_valid falls after the 16th pop.
  - o_count=0, o_aempty=1.
  - One further i_rd_en sets o_underflow.
- Run 40 cycles of simultaneous write+pop at count=8 with incrementing data:
  - o_count stays 8.
  - Popped data is in order across pointer wrap-around.
- At count=10, assert i_flush together with i_wr_en and i_rd_en: next cycle o_count=0, o_rd_valid=0, o_full=0, and the written word is not stored.
- With o_overflow=1, pulse i_clr_err: o_overflow=0 next cycle. Then assert i_rst_n low mid-stream: all outputs return to reset values immediately, without waiting for a clock edge.
